wb_arbiter: RTL
===============

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have no parameters; data 8 bits, register address 4 bits (16 registers), load tag FIFO depth 4.
REQ-002 SHALL have one clock and an asynchronous, active-low reset.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 alu_valid  in  1  ALU result offered.
REQ-006 alu_reg  in  4  ALU destination register.
REQ-007 alu_data  in  8  ALU result.
REQ-008 alu_ready  out  1  ALU result accepted this cycle when high with alu_valid.
REQ-009 load_issue  in  1  load request offered.
REQ-010 load_reg  in  4  load destination register.
REQ-011 load_ready  out  1  load tag accepted this cycle when high with load_issue.
REQ-012 mem_valid  in  1  load data returning, in issue order, never stallable.
REQ-013 mem_data  in  8  load data.
REQ-014 RegWrite, write_register (4), data_in (8)  out  registered write port to the register file.
REQ-015 raddrA, raddrB  in  4  register file read addresses.
REQ-016 data_outA, data_outB  in  8  register file read data.
REQ-017 fwdA, fwdB  out  8  operand values after bypass.
REQ-018 busyA, busyB  out  1  operand not yet valid (hazard; consumer stalls).

Function
REQ-019 Load tag FIFO: load_issue && load_ready pushes load_reg and sets pending[load_reg]; mem_valid with FIFO non-empty pops head tag and schedules write of mem_data to it.
REQ-020 load_ready = FIFO not full && !pending[load_reg] && !(hold_full && hold_reg == load_reg); computed from current state only.
REQ-021 alu_ready = !hold_full && !pending[alu_reg].
REQ-022 Write-port priority per cycle: memory return > hold buffer > newly accepted ALU result.
REQ-023 Accepted ALU result that loses arbitration SHALL be stored in the 1-entry hold buffer (hold_full, hold_reg, hold_data).
REQ-024 Winning write SHALL appear on RegWrite/write_register/data_in the next cycle (1-cycle latency); RegWrite low in cycles with no winner.
REQ-025 pending[tag] SHALL clear on the edge the memory write is registered; set and clear never coincide on one register (REQ-020).
REQ-026 mem_valid with empty FIFO SHALL be ignored: no write, no state change.
REQ-027 FIFO pointers wrap modulo 4; full = 4 entries, empty = 0; push and pop in one cycle leave count unchanged.
REQ-028 busyA = pending[raddrA]; busyB = pending[raddrB] (see REQ-033 for additions).
REQ-029 fwdA/fwdB default to data_outA/data_outB.

Reset
REQ-030 rst_n low SHALL asynchronously clear FIFO (empty), pending to 0, hold_full to 0, RegWrite to 0, write_register to 0, data_in to 0.
REQ-031 Reset mid-operation SHALL discard outstanding loads and held results; mem_valid after release with empty FIFO is ignored per REQ-026.
REQ-032 Combinational outputs after reset: alu_ready 1, load_ready 1, busyA/busyB 0, fwdA/fwdB = data_outA/data_outB.

Configuration
REQ-033 Macro WB_FORWARD_EN defined: fwdA = data_in when RegWrite && write_register == raddrA, else data_outA (same for B); busy per REQ-028 only.
REQ-034 WB_FORWARD_EN undefined: no bypass, fwdA/fwdB = data_outA/data_outB; busyA additionally asserted when RegWrite && write_register == raddrA (same for B).

Verification
REQ-035 Reset, alu_valid=1 alu_reg=3 alu_data=0x5A -> next cycle RegWrite=1 write_register=3 data_in=0x5A; with WB_FORWARD_EN and raddrA=3, fwdA=0x5A that cycle.
REQ-036 Issue loads to r1,r2,r4,r7 -> 5th load_issue (r8) sees load_ready=0; mem_valid with 0x11,0x22 -> writes r1=0x11 then r2=0x22 in consecutive cycles, pending[1],[2] cleared.
REQ-037 Same cycle mem_valid (head r5, 0x99) and alu_valid (r6, 0x44) -> cycle+1 writes r5=0x99, alu_ready=0 in cycle+1, cycle+2 writes r6=0x44.
REQ-038 Load pending on r9, alu_valid alu_reg=9 -> alu_ready=0 and busyA=1 (raddrA=9) until r9 memory write registers, then alu_ready=1.
REQ-039 mem_valid=1 with empty FIFO -> RegWrite stays 0; rst_n low with 3 loads outstanding -> load_ready=1, busy 0, subsequent mem_valid ignored.

Source files
------------

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges returning load data and ALU results onto one registered
// register-file write port, tracks load hazards, and bypasses operands when WB_FORWARD_EN is defined.
module wb_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       alu_valid,
  input  logic [3:0] alu_reg,
  input  logic [7:0] alu_data,
  output logic       alu_ready,
  input  logic       load_issue,
  input  logic [3:0] load_reg,
  output logic       load_ready,
  input  logic       mem_valid,
  input  logic [7:0] mem_data,
  output logic       RegWrite,
  output logic [3:0] write_register,
  output logic [7:0] data_in,
  input  logic [3:0] raddrA,
  input  logic [3:0] raddrB,
  input  logic [7:0] data_outA,
  input  logic [7:0] data_outB,
  output logic [7:0] fwdA,
  output logic [7:0] fwdB,
  output logic       busyA,
  output logic       busyB
);

  // Handshakes: a transfer happens on a rising edge where valid/issue and ready are both high;
  // ready depends only on registered state and the offered register number, never on valid.
  logic [3:0]  r_fifo [0:3];
  logic [1:0]  r_wptr;
  logic [1:0]  r_rptr;
  logic [2:0]  r_count;
  logic [15:0] r_pending;
  logic        r_hold_full;
  logic [3:0]  r_hold_reg;
  logic [7:0]  r_hold_data;

  logic        w_fifo_full;
  logic        w_fifo_empty;
  logic        w_load_push;
  logic        w_mem_pop;
  logic        w_alu_acc;
  logic [3:0]  w_head_reg;
  logic        w_wr_en;
  logic [3:0]  w_wr_reg;
  logic [7:0]  w_wr_data;
  logic [15:0] w_pend_set;
  logic [15:0] w_pend_clr;

  assign w_fifo_full  = (r_count == 3'd4);
  assign w_fifo_empty = (r_count == 3'd0);
  assign w_head_reg   = r_fifo[r_rptr];

  assign load_ready = !w_fifo_full && !r_pending[load_reg] &&
                      !(r_hold_full && (r_hold_reg == load_reg));
  assign alu_ready  = !r_hold_full && !r_pending[alu_reg];

  assign w_load_push = load_issue && load_ready;
  assign w_mem_pop   = mem_valid && !w_fifo_empty;
  assign w_alu_acc   = alu_valid && alu_ready;

  // Memory returns cannot stall, so they always win; the held result outranks a fresh one.
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_reg  = 4'd0;
    w_wr_data = 8'd0;
    if (w_mem_pop) begin
      w_wr_en   = 1'b1;
      w_wr_reg  = w_head_reg;
      w_wr_data = mem_data;
    end else if (r_hold_full) begin
      w_wr_en   = 1'b1;
      w_wr_reg  = r_hold_reg;
      w_wr_data = r_hold_data;
    end else if (w_alu_acc) begin
      w_wr_en   = 1'b1;
      w_wr_reg  = alu_reg;
      w_wr_data = alu_data;
    end
  end

  always_comb begin
    w_pend_set = 16'd0;
    w_pend_clr = 16'd0;
    if (w_load_push) w_pend_set = 16'd1 << load_reg;
    if (w_mem_pop)   w_pend_clr = 16'd1 << w_head_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_fifo[i] <= 4'd0;
      r_wptr         <= 2'd0;
      r_rptr         <= 2'd0;
      r_count        <= 3'd0;
      r_pending      <= 16'd0;
      r_hold_full    <= 1'b0;
      r_hold_reg     <= 4'd0;
      r_hold_data    <= 8'd0;
      RegWrite       <= 1'b0;
      write_register <= 4'd0;
      data_in        <= 8'd0;
    end else begin
      if (w_load_push) begin
        r_fifo[r_wptr] <= load_reg;
        r_wptr         <= r_wptr + 2'd1;
      end
      if (w_mem_pop) r_rptr <= r_rptr + 2'd1;
      case ({w_load_push, w_mem_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
      r_pending <= (r_pending | w_pend_set) & ~w_pend_clr;
      // An accepted ALU result implies the hold buffer was empty, so it only loses to memory.
      if (w_alu_acc && w_mem_pop) begin
        r_hold_full <= 1'b1;
        r_hold_reg  <= alu_reg;
        r_hold_data <= alu_data;
      end else if (r_hold_full && !w_mem_pop) begin
        r_hold_full <= 1'b0;
      end
      RegWrite       <= w_wr_en;
      write_register <= w_wr_reg;
      data_in        <= w_wr_data;
    end
  end

`ifdef WB_FORWARD_EN
  assign fwdA  = (RegWrite && (write_register == raddrA)) ? data_in : data_outA;
  assign fwdB  = (RegWrite && (write_register == raddrB)) ? data_in : data_outB;
  assign busyA = r_pending[raddrA];
  assign busyB = r_pending[raddrB];
`else
  // Without bypass the value being written this cycle is not yet readable.
  assign fwdA  = data_outA;
  assign fwdB  = data_outB;
  assign busyA = r_pending[raddrA] || (RegWrite && (write_register == raddrA));
  assign busyB = r_pending[raddrB] || (RegWrite && (write_register == raddrB));
`endif

endmodule
